// File: rtl/cail_pkg.sv
// Shared types and constants for the calibration-coefficient loader.
// Bank layout: word 2c = channel c offset, word 2c+1 = channel c gain.
package cail_pkg;

    localparam int CH_NUM       = 8;
    localparam int BYTES_PER_CH = 8;
    localparam int NBYTES       = CH_NUM * BYTES_PER_CH;
    localparam int NWORDS       = NBYTES / 4;

    localparam logic [31:0] FLOAT_ONE  = 32'h3F800000;
    localparam logic [31:0] FLOAT_ZERO = 32'h0;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_REQ,
        LD_WAIT,
        LD_NEXT,
        LD_COMMIT
    } ld_state_e;

    typedef logic [CH_NUM-1:0][31:0] coef_bank_t;
    typedef logic [NWORDS-1:0][31:0] word_bank_t;

    // Identity bank: zero offset, unity gain on every channel.
    function automatic word_bank_t default_bank();
        word_bank_t b;
        for (int w = 0; w < NWORDS; w++) begin
            b[w] = (w % 2 == 1) ? FLOAT_ONE : FLOAT_ZERO;
        end
        return b;
    endfunction

endpackage

// File: rtl/cail_coef_loader_seq.sv
// Conversion-slot sequencer: walks seq_cnt after cail_en and presents
// the active offsets and gains in their per-channel windows.
module cail_seq
    import cail_pkg::*;
#(
    parameter int SUB_DLY  = 5,
    parameter int MULT_DLY = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  coef_bank_t  offs_i,
    input  coef_bank_t  gain_i,
    output logic        idle_o,
    output logic [31:0] sub_o,
    output logic [31:0] mult_o
);

    localparam logic [4:0] SUB_LO = 5'(SUB_DLY);
    localparam logic [4:0] SUB_HI = 5'(SUB_DLY + CH_NUM - 1);
    localparam logic [4:0] MUL_LO = 5'(MULT_DLY);
    localparam logic [4:0] MUL_HI = 5'(MULT_DLY + CH_NUM - 1);

    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] sub_q, sub_d;
    logic [31:0] mult_q, mult_d;
    logic [2:0]  sub_idx, mul_idx;

    // Next count and registered window muxing from the active bank.
    always_comb begin
        cnt_d   = cnt_q;
        sub_d   = FLOAT_ZERO;
        mult_d  = FLOAT_ZERO;
        sub_idx = 3'(cnt_q - SUB_LO);
        mul_idx = 3'(cnt_q - MUL_LO);
        if (cnt_q == 5'd0) begin
            if (en_i) begin
                cnt_d = 5'd1;
            end
        end else if (cnt_q == MUL_HI) begin
            cnt_d = 5'd0;
        end else begin
            cnt_d = cnt_q + 5'd1;
        end
        if (cnt_q >= SUB_LO && cnt_q <= SUB_HI) begin
            sub_d = offs_i[sub_idx];
        end
        if (cnt_q >= MUL_LO && cnt_q <= MUL_HI) begin
            mult_d = gain_i[mul_idx];
        end
    end

    // Counter and output registers; reset clears any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            sub_q  <= FLOAT_ZERO;
            mult_q <= FLOAT_ZERO;
        end else begin
            cnt_q  <= cnt_d;
            sub_q  <= sub_d;
            mult_q <= mult_d;
        end
    end

    assign idle_o = (cnt_q == 5'd0);
    assign sub_o  = sub_q;
    assign mult_o = mult_q;

endmodule

// File: rtl/cail_coef_loader.sv
// Loads 8 x (offset, gain) floats byte-wise from EEPROM into a shadow
// bank, commits atomically between sequences, and streams them out.
module cail_coef_loader
    import cail_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR = 10'd0,
    parameter int          SUB_DLY   = 5,
    parameter int          MULT_DLY  = 12,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done_i,
    input  logic        reload_i,
    output logic        ee_rd_req_o,
    output logic [9:0]  ee_rd_addr_o,
    input  logic        ee_rd_valid_i,
    input  logic [7:0]  ee_rd_data_i,
    input  logic        cail_en_i,
    output logic [31:0] cail_sub_o,
    output logic [31:0] cail_mult_o,
    output logic        busy_o,
    output logic        load_done_o,
    output logic        err_o
);

    ld_state_e   st_q, st_d;
    logic [5:0]  b_q, b_d;
    logic [31:0] asm_q, asm_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        done_q;
    logic        init_q;
    logic        start;
    logic        shd_we;
    logic        commit;
    logic        seq_idle;
    word_bank_t  shd_q, act_q;
    coef_bank_t  offs, gain;

    assign start = (init_done_i & ~init_q) | reload_i;

    // Load FSM next-state; commit waits for an idle sequencer.
    always_comb begin
        st_d   = st_q;
        b_d    = b_q;
        asm_d  = asm_q;
        tmo_d  = tmo_q;
        err_d  = err_q;
        shd_we = 1'b0;
        commit = 1'b0;
        unique case (st_q)
            LD_IDLE: begin
                if (start) begin
                    st_d  = LD_REQ;
                    b_d   = 6'd0;
                    err_d = 1'b0;
                end
            end
            LD_REQ: begin
                st_d  = LD_WAIT;
                tmo_d = 16'd0;
            end
            LD_WAIT: begin
                if (ee_rd_valid_i) begin
                    asm_d = {asm_q[23:0], ee_rd_data_i};
                    st_d  = LD_NEXT;
                end else if (tmo_q == TIMEOUT) begin
                    err_d = 1'b1;
                    st_d  = LD_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            LD_NEXT: begin
                shd_we = (b_q[1:0] == 2'd3);
                if (b_q == 6'd63) begin
                    st_d = LD_COMMIT;
                end else begin
                    b_d  = b_q + 6'd1;
                    st_d = LD_REQ;
                end
            end
            LD_COMMIT: begin
                if (seq_idle) begin
                    commit = 1'b1;
                    st_d   = LD_IDLE;
                end
            end
            default: st_d = LD_IDLE;
        endcase
    end

    // Load FSM state; the init edge detector tracks its input in reset
    // so a level already high at reset release does not start a load.
    always_ff @(posedge clk) begin
        init_q <= init_done_i;
        if (rst) begin
            st_q   <= LD_IDLE;
            b_q    <= 6'd0;
            asm_q  <= 32'd0;
            tmo_q  <= 16'd0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            b_q    <= b_d;
            asm_q  <= asm_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
            done_q <= commit;
        end
    end

    // Shadow fills word by word; active bank swaps in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_q <= default_bank();
            act_q <= default_bank();
        end else begin
            if (shd_we) begin
                shd_q[b_q[5:2]] <= asm_q;
            end
            if (commit) begin
                act_q <= shd_q;
            end
        end
    end

    // Split interleaved bank words into per-channel offset/gain views.
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            offs[c] = act_q[2*c];
            gain[c] = act_q[2*c+1];
        end
    end

    cail_seq #(
        .SUB_DLY  (SUB_DLY),
        .MULT_DLY (MULT_DLY)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .en_i   (cail_en_i),
        .offs_i (offs),
        .gain_i (gain),
        .idle_o (seq_idle),
        .sub_o  (cail_sub_o),
        .mult_o (cail_mult_o)
    );

    assign ee_rd_req_o  = (st_q == LD_REQ);
    assign ee_rd_addr_o = ee_rd_req_o ? BASE_ADDR + {4'd0, b_q} : 10'd0;
    assign busy_o       = (st_q != LD_IDLE);
    assign load_done_o  = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/cail_coef_loader.md
Name: cail_coef_loader

Overview:
- Calibration-coefficient stage between eeprom_ctrl and the AD7606 acquisition path (ad_control_top).
- Fetches 8 channels × (offset, gain) IEEE-754 single-precision coefficients byte-wise from EEPROM into a shadow bank, then commits them atomically to an active bank.
- On each cail_en pulse, streams the active offsets and gains onto cail_sub/cail_mult in the per-channel conversion-slot timing.

Parameters:
- BASE_ADDR, 10'd0: EEPROM byte address of channel 0 offset MSB.
- SUB_DLY, 5: sequence count at which channel 0 offset is presented.
- MULT_DLY, 12: sequence count at which channel 0 gain is presented.
- TIMEOUT, 16'd50000: maximum clk cycles to wait for one byte read.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- init_done_i  in  1  eeprom_ctrl init complete; rising edge starts a load
- reload_i  in  1  single-cycle request for a fresh load (Modbus update)
- ee_rd_req_o  out  1  single-cycle byte read request
- ee_rd_addr_o  out  10  byte address, valid with ee_rd_req_o
- ee_rd_valid_i  in  1  byte returned
- ee_rd_data_i  in  8  returned byte, valid with ee_rd_valid_i
- cail_en_i  in  1  sequence start pulse from ad_control_top
- cail_sub_o  out  32  offset coefficient (float)
- cail_mult_o  out  32  gain coefficient (float)
- busy_o  out  1  load in progress
- load_done_o  out  1  one-cycle pulse when the active bank is committed
- err_o  out  1  sticky: a byte read timed out

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - cail_sub_o = 0, cail_mult_o = 0.
  - busy_o, load_done_o, err_o, ee_rd_req_o = 0; ee_rd_addr_o = 0.
  - Active bank: every offset = 32'h00000000, every gain = 32'h3F800000 (1.0), so the path is identity until the first load.
- EEPROM layout, big-endian:
  - Channel c (0..7) offset at BASE_ADDR + 8c + 0..3.
  - Channel c gain at BASE_ADDR + 8c + 4..7.
  - 64 bytes total; byte index b = 0..63.
- Load FSM states: IDLE, REQ, WAIT, NEXT, COMMIT.
  - IDLE: a rising edge of init_done_i, or reload_i, goes to REQ with b = 0, busy_o = 1, and err_o cleared.
  - REQ: drive ee_rd_req_o = 1 for one cycle with ee_rd_addr_o = BASE_ADDR + b, then go to WAIT and clear the timeout counter.
  - WAIT: on ee_rd_valid_i, shift ee_rd_data_i into a 32-bit assembly register ({asm[23:0], data}) and go to NEXT. If the counter reaches TIMEOUT, set err_o, set busy_o = 0, return to IDLE, and leave the active bank unchanged.
  - NEXT: on b[1:0] == 3, write the assembly register to shadow word b[5:2]. If b == 63, go to COMMIT; otherwise increment b and go to REQ.
  - COMMIT: copy the shadow bank to the active bank in one cycle, pulse load_done_o, set busy_o = 0, and go to IDLE.
- Load requests arriving while busy_o = 1 are ignored. ee_rd_valid_i outside WAIT is ignored.
- Sequencer, independent of the load FSM:
  - A 5-bit seq_cnt idles at 0.
  - cail_en_i while seq_cnt == 0 sets seq_cnt = 1, then seq_cnt increments every cycle up to MULT_DLY + 7 and returns to 0.
  - cail_en_i while seq_cnt != 0 is ignored.
  - Outputs are registered (one cycle after the seq_cnt value):
    - seq_cnt in SUB_DLY..SUB_DLY+7: cail_sub_o = active offset[seq_cnt - SUB_DLY]; otherwise 0.
    - seq_cnt in MULT_DLY..MULT_DLY+7: cail_mult_o = active gain[seq_cnt - MULT_DLY]; otherwise 0.
    - With the defaults the windows overlap at seq_cnt 12 (channel 7 offset and channel 0 gain together).
- Collision: if COMMIT coincides with an active sequence, the commit is deferred until seq_cnt == 0, so one sequence never mixes banks. load_done_o pulses on the actual commit cycle.
- Reset mid-load aborts the load and restores the default bank. Reset mid-sequence forces the outputs to 0.

Decomposition:
- Shared package cail_pkg:
  - CH_NUM = 8; BYTES_PER_CH = 8.
  - FLOAT_ONE = 32'h3F800000; FLOAT_ZERO = 32'h0.
  - Load-state encoding.
- One natural sub-module, cail_seq: the seq_cnt counter plus the output muxing from the active bank.

Test Plan:
- Reset, then cail_en_i pulse → cail_sub_o = 0 every cycle; cail_mult_o = 32'h3F800000 for 8 consecutive cycles starting at seq_cnt 12 (+1 registered); then 0.
- init_done_i rising with an EEPROM model returning byte value = address, 3-cycle read latency:
  - → 64 reads at addresses 0..63.
  - → load_done_o pulses once, busy_o falls.
  - → next sequence gives offset ch0 = 32'h00010203, gain ch7 = 32'h3C3D3E3F.
- Model stops responding at byte 20 → err_o = 1 after TIMEOUT cycles; busy_o = 0; outputs still show the previous bank.
- reload_i timed so COMMIT lands at seq_cnt = 8 → the current sequence shows only old values; load_done_o fires on the cycle after seq_cnt returns to 0; the next sequence shows only new values.
- Second cail_en_i at seq_cnt = 10 → ignored; the sequence ends at MULT_DLY + 7 as normal.
- rst asserted at byte 30 of a load → no further reads; active bank returns to defaults; reload_i afterwards starts again at address BASE_ADDR.
